// File: rtl/pkg_blkmov.sv
// Shared types and helpers for the block-move engine: FSM states, the
// command bundle captured at start, and the byte stride of one word.
package pkg_blkmov;

  // Default geometry; the command bundle is sized to these widths.
  localparam int PKG_ADDR_W = 32;
  localparam int PKG_IDX_W  = 4;
  localparam int PKG_CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_RD,
    FINISH
  } state_t;

  typedef struct packed {
    logic                  dir_store;
    logic                  ptr_dec;
    logic                  ptr_pre;
    logic [PKG_ADDR_W-1:0] ptr_in;
    logic [PKG_IDX_W-1:0]  first_reg;
    logic [PKG_CNT_W-1:0]  count;
  } cmd_t;

  // Bytes the pointer moves per transferred word.
  function automatic int unsigned stride_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/blkmov_addr_gen.sv
// Pointer accumulator for the block-move engine. The register always holds
// the post-adjust address of the current word; pre-adjust mode looks one
// stride ahead. After N steps the register equals the final pointer.
module blkmov_addr_gen #(
  parameter int          ADDR_W = 32,
  parameter int unsigned STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] ptr_in,
  input  logic              step,
  input  logic              dec,
  input  logic              pre,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] final_ptr
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] next_ptr;

  // One stride away from the current pointer in the selected direction.
  always_comb begin
    next_ptr  = dec ? (ptr_q - STEP) : (ptr_q + STEP);
    addr      = pre ? next_ptr : ptr_q;
    final_ptr = ptr_q;
  end

  // Load the start pointer on command accept, advance once per accepted access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (load) begin
      ptr_q <= ptr_in;
    end else if (step) begin
      ptr_q <= next_ptr;
    end
  end

endmodule

// File: rtl/blkmov_engine.sv
// Multi-cycle block-move unit: moves up to MAX_REGS consecutive GPRs to or
// from memory through a pointer, one outstanding memory request at a time.
module blkmov_engine
  import pkg_blkmov::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_GPRS = 16,
  parameter int MAX_REGS = 8,
  localparam int IDX_W   = $clog2(NUM_GPRS),
  localparam int CNT_W   = $clog2(MAX_REGS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dir_store,
  input  logic              ptr_dec,
  input  logic              ptr_pre,
  input  logic [ADDR_W-1:0] ptr_in,
  input  logic [IDX_W-1:0]  first_reg,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ptr_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [IDX_W-1:0]  reg_idx,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata
);

  localparam int unsigned      STRIDE  = stride_bytes(DATA_W);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_REGS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  cmd_t             cmd_in;
  logic [CNT_W-1:0] count_clamped;
  logic             dir_q;
  logic             dec_q;
  logic             pre_q;
  logic [CNT_W-1:0] rem_q;
  logic [IDX_W-1:0] idx_q;
  logic             ag_load;
  logic             ag_step;

  // Bundle the incoming command, clamping oversize word counts.
  always_comb begin
    count_clamped    = (count > MAX_CNT) ? MAX_CNT : count;
    cmd_in.dir_store = dir_store;
    cmd_in.ptr_dec   = ptr_dec;
    cmd_in.ptr_pre   = ptr_pre;
    cmd_in.ptr_in    = PKG_ADDR_W'(ptr_in);
    cmd_in.first_reg = PKG_IDX_W'(first_reg);
    cmd_in.count     = PKG_CNT_W'(count_clamped);
  end

  assign ag_load = (state == IDLE) && start;
  assign ag_step = (state == ISSUE) && mem_ready;

  blkmov_addr_gen #(
    .ADDR_W (ADDR_W),
    .STRIDE (STRIDE)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ag_load),
    .ptr_in    (ADDR_W'(cmd_in.ptr_in)),
    .step      (ag_step),
    .dec       (dec_q),
    .pre       (pre_q),
    .addr      (mem_addr),
    .final_ptr (ptr_out)
  );

  // Control FSM with registered outputs; a load writeback overlaps the next issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      dec_q     <= 1'b0;
      pre_q     <= 1'b0;
      rem_q     <= '0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      reg_idx   <= '0;
      reg_we    <= 1'b0;
      reg_wdata <= '0;
    end else begin
      done   <= 1'b0;
      reg_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            dir_q  <= cmd_in.dir_store;
            dec_q  <= cmd_in.ptr_dec;
            pre_q  <= cmd_in.ptr_pre;
            rem_q  <= CNT_W'(cmd_in.count);
            idx_q  <= IDX_W'(cmd_in.first_reg);
            mem_we <= cmd_in.dir_store;
            if (cmd_in.count == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else if (cmd_in.dir_store) begin
              state   <= FETCH;
              reg_idx <= IDX_W'(cmd_in.first_reg);
            end else begin
              state   <= ISSUE;
              mem_req <= 1'b1;
            end
          end
        end
        FETCH: begin
          mem_wdata <= reg_rdata;
          mem_req   <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (dir_q) begin
              rem_q <= rem_q - ONE;
              if (rem_q == ONE) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                state   <= FETCH;
                idx_q   <= idx_q + 1'b1;
                reg_idx <= idx_q + 1'b1;
              end
            end else begin
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (mem_rdata_valid) begin
            reg_we    <= 1'b1;
            reg_idx   <= idx_q;
            reg_wdata <= mem_rdata;
            idx_q     <= idx_q + 1'b1;
            rem_q     <= rem_q - ONE;
            if (rem_q == ONE) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              mem_req <= 1'b1;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blkmov_engine.sv
// Self-checking bench for blkmov_engine: directed commands, a memory and GPR
// model around the DUT, and scoreboard queues of expected memory requests,
// GPR writebacks and completions.
module tb_blkmov_engine;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int NUM_GPRS = 16;
  localparam int MAX_REGS = 8;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] ptr;
    int                cyc;
  } done_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              dir_store;
  logic              ptr_dec;
  logic              ptr_pre;
  logic [ADDR_W-1:0] ptr_in;
  logic [IDX_W-1:0]  first_reg;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ptr_out;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic [IDX_W-1:0]  reg_idx;
  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  req_t  exp_req[$];
  wr_t   exp_wr[$];
  done_t exp_done[$];

  logic [DATA_W-1:0] gpr[NUM_GPRS];
  logic [DATA_W-1:0] ref_gpr[NUM_GPRS];
  logic [ADDR_W-1:0] last_final;

  int checks       = 0;
  int failures     = 0;
  int cyc          = 0;
  int stall_word   = -1;
  int stall_cycles = 0;
  int acc_cnt      = 0;
  int wait_cnt     = 0;

  blkmov_engine #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_GPRS (NUM_GPRS),
    .MAX_REGS (MAX_REGS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .dir_store       (dir_store),
    .ptr_dec         (ptr_dec),
    .ptr_pre         (ptr_pre),
    .ptr_in          (ptr_in),
    .first_reg       (first_reg),
    .count           (count),
    .busy            (busy),
    .done            (done),
    .ptr_out         (ptr_out),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ready       (mem_ready),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .reg_idx         (reg_idx),
    .reg_we          (reg_we),
    .reg_wdata       (reg_wdata),
    .reg_rdata       (reg_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // GPR file seen by the DUT, written only through its writeback port.
  assign reg_rdata = gpr[reg_idx];
  always @(posedge clk) begin
    if (reg_we) gpr[reg_idx] <= reg_wdata;
  end

  // Memory: accepts a request unless the configured word is being stalled.
  assign mem_ready = mem_req && !(acc_cnt == stall_word && wait_cnt < stall_cycles);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rdata_valid <= rst_n && mem_req && mem_ready && !mem_we;
    mem_rdata       <= mem_fn(mem_addr);
    if (start && !busy) begin
      acc_cnt  <= 0;
      wait_cnt <= 0;
    end else if (mem_req) begin
      if (mem_ready) begin
        acc_cnt  <= acc_cnt + 1;
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Scoreboard: compare DUT activity against the expected queues mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (exp_req.size() == 0) begin
          checkOutput("unexpected_mem_req", 64'(mem_req), 64'd0);
        end else begin
          checkOutput("mem_addr", 64'(mem_addr), 64'(exp_req[0].addr));
          checkOutput("mem_we", 64'(mem_we), 64'(exp_req[0].we));
          if (exp_req[0].we) checkOutput("mem_wdata", 64'(mem_wdata), 64'(exp_req[0].wdata));
          if (mem_ready) void'(exp_req.pop_front());
        end
      end
      if (reg_we) begin
        if (exp_wr.size() == 0) begin
          checkOutput("unexpected_reg_we", 64'(reg_we), 64'd0);
        end else begin
          checkOutput("reg_idx", 64'(reg_idx), 64'(exp_wr[0].idx));
          checkOutput("reg_wdata", 64'(reg_wdata), 64'(exp_wr[0].data));
          ref_gpr[exp_wr[0].idx] = exp_wr[0].data;
          void'(exp_wr.pop_front());
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'd0);
        end else begin
          checkOutput("ptr_out", 64'(ptr_out), 64'(exp_done[0].ptr));
          checkOutput("done_cycle", 64'(cyc), 64'(exp_done[0].cyc));
          checkOutput("busy_at_done", 64'(busy), 64'd1);
          void'(exp_done.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic st, input logic dec, input logic pre,
                               input logic [ADDR_W-1:0] p, input logic [IDX_W-1:0] fr,
                               input logic [CNT_W-1:0] cnt, input int sw, input int sc);
    int n;
    int lat;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] fin;
    logic [IDX_W-1:0]  idx;
    n = (int'(cnt) > MAX_REGS) ? MAX_REGS : int'(cnt);
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      off = 32'((pre ? k + 1 : k) * 4);
      a   = dec ? p - off : p + off;
      idx = fr + IDX_W'(k);
      if (st) begin
        exp_req.push_back('{addr: a, we: 1'b1, wdata: ref_gpr[idx]});
      end else begin
        exp_req.push_back('{addr: a, we: 1'b0, wdata: '0});
        exp_wr.push_back('{idx: idx, data: mem_fn(a)});
      end
    end
    fin = dec ? p - 32'(n * 4) : p + 32'(n * 4);
    lat = (n == 0) ? 1 : 2 * n + 1 + ((sw >= 0 && sw < n) ? sc : 0);
    exp_done.push_back('{ptr: fin, cyc: cyc + lat});
    last_final   = fin;
    stall_word   = sw;
    stall_cycles = sc;
    dir_store    = st;
    ptr_dec      = dec;
    ptr_pre      = pre;
    ptr_in       = p;
    first_reg    = fr;
    count        = cnt;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checkOutput({tag, "_done_timeout"}, 64'd0, 64'd1);
      exp_req.delete();
      exp_wr.delete();
      exp_done.delete();
    end else begin
      @(negedge clk);
      checkOutput({tag, "_ptr_hold"}, 64'(ptr_out), 64'(last_final));
      checkOutput({tag, "_busy_clear"}, 64'(busy), 64'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string pfx);
    checkOutput({pfx, "_busy"}, 64'(busy), 64'd0);
    checkOutput({pfx, "_done"}, 64'(done), 64'd0);
    checkOutput({pfx, "_ptr_out"}, 64'(ptr_out), 64'd0);
    checkOutput({pfx, "_mem_req"}, 64'(mem_req), 64'd0);
    checkOutput({pfx, "_mem_we"}, 64'(mem_we), 64'd0);
    checkOutput({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
    checkOutput({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    checkOutput({pfx, "_reg_idx"}, 64'(reg_idx), 64'd0);
    checkOutput({pfx, "_reg_we"}, 64'(reg_we), 64'd0);
    checkOutput({pfx, "_reg_wdata"}, 64'(reg_wdata), 64'd0);
  endtask

  // Directed sequence of commands.
  initial begin
    for (int i = 0; i < NUM_GPRS; i++) begin
      gpr[i]     = 32'h1000_0000 + 32'(i * 32'h11);
      ref_gpr[i] = 32'h1000_0000 + 32'(i * 32'h11);
    end
    rst_n     = 1'b0;
    start     = 1'b0;
    dir_store = 1'b0;
    ptr_dec   = 1'b0;
    ptr_pre   = 1'b0;
    ptr_in    = '0;
    first_reg = '0;
    count     = '0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] load N=3 inc/post from 0x100, GPR 14 upward");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'd14, 4'd3, -1, 0);
    waitDone("load_inc_post");

    $display("[TB] store N=2 dec/pre from 0x200, GPR 3 upward");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200, 4'd3, 4'd2, -1, 0);
    waitDone("store_dec_pre");

    $display("[TB] zero-count command");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h1234_5678, 4'd0, 4'd0, -1, 0);
    waitDone("count_zero");

    $display("[TB] load with 5-cycle ready stall on word 1 and a start while busy");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0300, 4'd1, 4'd3, 1, 5);
    repeat (2) @(negedge clk);
    dir_store = 1'b1;
    ptr_in    = 32'hDEAD_0000;
    count     = 4'd2;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    waitDone("stall_word1");

    $display("[TB] load N=2 dec/post from 0x10");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0010, 4'd7, 4'd2, -1, 0);
    waitDone("load_dec_post");

    $display("[TB] load N=1 inc/pre wrapping past the top of memory");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 4'd15, 4'd1, -1, 0);
    waitDone("load_inc_pre_wrap");

    $display("[TB] reset during the read wait of the second word");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0400, 4'd5, 4'd3, -1, 0);
    for (int i = 0; i < 50; i++) begin
      if (acc_cnt == 2) break;
      @(negedge clk);
    end
    checkOutput("reset_point_reached", 64'(acc_cnt), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midreset");
    exp_req.delete();
    exp_wr.delete();
    exp_done.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] store with count=15 clamped to 8, wrapping from 0xFFFFFFF8");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 4'd10, 4'd15, -1, 0);
    waitDone("store_clamp_wrap");

    checkOutput("req_queue_empty", 64'(exp_req.size()), 64'd0);
    checkOutput("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    checkOutput("done_queue_empty", 64'(exp_done.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/blkmov_engine.md
Name: blkmov_engine

Overview:
- Parametrised multi-cycle block-move unit that transfers COUNT consecutive GPRs to or from memory through a pointer register.
- Supports increment or decrement addressing, pre- or post-adjust, and register-index wrap-around.
- Sits beside the CPU control FSM. The FSM hands it a start command and stalls in its execute state until done; the unit owns the memory port for the duration.
- Replaces fixed per-stride pointer adders with one stride accumulator generalised in data width and register count.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8. Stride S = DATA_W/8 bytes.
- ADDR_W, 32: address/pointer width.
- NUM_GPRS, 16: GPR file depth; a power of 2. IDX_W = $clog2(NUM_GPRS).
- MAX_REGS, 8: maximum words per move. CNT_W = $clog2(MAX_REGS+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- dir_store  in  1  0 = load (mem->regs), 1 = store (regs->mem)
- ptr_dec  in  1  0 = increment pointer, 1 = decrement pointer
- ptr_pre  in  1  1 = adjust before each access, 0 = adjust after
- ptr_in  in  ADDR_W  starting pointer value
- first_reg  in  IDX_W  first GPR index
- count  in  CNT_W  words to move; values above MAX_REGS clamp to MAX_REGS
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- ptr_out  out  ADDR_W  final pointer, valid while done=1 and held until the next start
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write request (store)
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  store data
- mem_ready  in  1  request accepted this cycle
- mem_rdata_valid  in  1  load data returned
- mem_rdata  in  DATA_W  load data
- reg_idx  out  IDX_W  GPR index for read (store) or write (load)
- reg_we  out  1  GPR write strobe
- reg_wdata  out  DATA_W  GPR write data
- reg_rdata  in  DATA_W  GPR read data, combinational from reg_idx

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; every output 0, including ptr_out. Reset during a transfer drops mem_req immediately; the in-flight access is abandoned with no done.
- States: IDLE, FETCH (store only), ISSUE, WAIT_RD (load only), FINISH.
- IDLE with start=1: latch the command. For count=0, go to FINISH with ptr_out=ptr_in and make no memory access. Otherwise go to FETCH (store) or ISSUE (load). start while busy is ignored.
- Address k (k = 0..N-1):
  - inc/post: p+k*S
  - inc/pre: p+(k+1)*S
  - dec/post: p-k*S
  - dec/pre: p-(k+1)*S
- Final pointer is p±N*S in all four modes. Arithmetic is modulo 2^ADDR_W, so wrap-around past 0 or the top of the address space is silent.
- Register k index is (first_reg+k) mod NUM_GPRS; wraps.
- FETCH (1 cycle): drive reg_idx; latch reg_rdata into mem_wdata; go to ISSUE.
- ISSUE: mem_req=1 with mem_addr, mem_we and mem_wdata stable until the mem_ready cycle. mem_req deasserts the cycle after mem_ready.
  - Store: next FETCH, or FINISH after the last word.
  - Load: go to WAIT_RD.
- WAIT_RD: on mem_rdata_valid, the next cycle has reg_we=1, reg_idx=word k, reg_wdata=mem_rdata. The FSM enters the next ISSUE (or FINISH) in that same cycle, overlapping the writeback.
- mem_rdata_valid outside WAIT_RD is ignored.
- FINISH (1 cycle): done=1, ptr_out valid; return to IDLE.
- Minimum latency, with mem_ready and rdata_valid each after 1 cycle:
  - store: 2N+1 cycles, start to done
  - load: 2N+1 cycles, start to done
- Only one outstanding memory request at any time.

Decomposition:
- Package pkg_blkmov: state enum, command struct {dir_store, ptr_dec, ptr_pre, ptr_in, first_reg, count}, and a stride-constant function.
- Sub-module blkmov_addr_gen: registered pointer accumulator with ±S step and pre/post offset. It outputs the current mem_addr and the final pointer.

Test Plan:
- Load, N=3, inc/post, ptr 0x100, first_reg 14 (NUM_GPRS=16) -> addresses 0x100, 0x104, 0x108; reg_we to GPRs 14, 15, 0; ptr_out 0x10C; done at cycle 7.
- Store, N=2, dec/pre, ptr 0x200, first_reg 3 -> writes to 0x1FC (data GPR3) and 0x1F8 (data GPR4); ptr_out 0x1F8.
- count=0 -> done on the cycle after start; ptr_out=ptr_in; mem_req never asserts.
- mem_ready held low 5 cycles on word 1 -> mem_req, mem_addr and mem_wdata remain stable; done is delayed by exactly 5 cycles.
- rst_n low during WAIT_RD of word 2 -> next cycle all outputs 0 and state IDLE; a new start executes normally.
- count=15 with MAX_REGS=8 -> exactly 8 transfers; inc/post from 0xFFFFFFF8 wraps to 0x00000000, 0x00000004, ...; ptr_out 0x00000018.
